// File: rtl/dvi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dvi_pkg
// Description : TMDS control tokens, receive-alignment state encoding and
//               small helpers shared by the DVI transmit and receive paths.
// Revision    : 1.0 - initial release
// ============================================================================
package dvi_pkg;

    localparam logic [9:0] c_tok_c00 = 10'b1101010100;
    localparam logic [9:0] c_tok_c01 = 10'b0010101011;
    localparam logic [9:0] c_tok_c10 = 10'b0101010100;
    localparam logic [9:0] c_tok_c11 = 10'b1010101011;

    localparam int         c_cnt_w   = 12;

    localparam logic [0:0] c_st_search = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    // Counters hold at all-ones instead of wrapping back to zero.
    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (v == {c_cnt_w{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_decode.sv
`default_nettype none
// ============================================================================
// Module      : tmds_decode
// Description : Combinational TMDS symbol classifier: control token vs data,
//               control bits and 8-bit transition-minimised data decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_decode
    import dvi_pkg::*;
(
    input  logic [9:0] i_sym,
    output logic       o_is_ctrl,
    output logic [1:0] o_c,
    output logic [7:0] o_data
);

    logic [7:0] w_d;

    assign w_d = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

    always_comb begin
        o_is_ctrl = 1'b1;
        o_c       = 2'b00;
        case (i_sym)
            c_tok_c00: o_c = 2'b00;
            c_tok_c01: o_c = 2'b01;
            c_tok_c10: o_c = 2'b10;
            c_tok_c11: o_c = 2'b11;
            default:   o_is_ctrl = 1'b0;
        endcase
    end

    // Bit 8 selects whether the encoder chained bits with XOR or XNOR.
    always_comb begin
        o_data    = 8'h00;
        o_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            o_data[i] = i_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dvi_rx_channel.sv
`default_nettype none
// ============================================================================
// Module      : dvi_rx_channel
// Description : One TMDS receive channel: bit-offset hunt on control tokens,
//               lock tracking, and two-stage symbol decode to DE/C/data.
// Revision    : 1.0 - initial release
// ============================================================================
module dvi_rx_channel
    import dvi_pkg::*;
#(
    parameter int LOCK_COUNT     = 64,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOSS_TIMEOUT   = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    output logic       locked,
    output logic [3:0] offset,
    output logic       de,
    output logic [1:0] c,
    output logic [7:0] data
);

    localparam logic [c_cnt_w-1:0] c_lock_cnt    = c_cnt_w'(LOCK_COUNT);
    localparam logic [c_cnt_w-1:0] c_search_last = c_cnt_w'(SEARCH_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_loss_last   = c_cnt_w'(LOSS_TIMEOUT - 1);

    logic [9:0]         r_din_prev;
    logic [19:0]        w_window;
    logic [9:0]         w_word;
    logic               w_is_ctrl;
    logic [1:0]         w_c;
    logic [7:0]         w_data;

    logic [0:0]         r_state,  w_state_next;
    logic [3:0]         r_offset, w_offset_next;
    logic [c_cnt_w-1:0] r_hits,   w_hits_next;
    logic [c_cnt_w-1:0] r_tmo,    w_tmo_next;
    logic [c_cnt_w-1:0] r_loss,   w_loss_next;

    logic               r_s1_is_ctrl;
    logic [1:0]         r_s1_c;
    logic [7:0]         r_s1_data;
    logic               r_s2_de;
    logic [1:0]         r_s2_c;
    logic [7:0]         r_s2_data;

    // Bit 0 arrives first, so the older word occupies the low half.
    assign w_window = {din, r_din_prev};
    assign w_word   = 10'(w_window >> r_offset);

    tmds_decode u_decode (
        .i_sym     (w_word),
        .o_is_ctrl (w_is_ctrl),
        .o_c       (w_c),
        .o_data    (w_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_search;
            r_offset   <= 4'd0;
            r_hits     <= '0;
            r_tmo      <= '0;
            r_loss     <= '0;
            r_din_prev <= 10'd0;
        end else begin
            r_state    <= w_state_next;
            r_offset   <= w_offset_next;
            r_hits     <= w_hits_next;
            r_tmo      <= w_tmo_next;
            r_loss     <= w_loss_next;
            r_din_prev <= din;
        end
    end

    // Counters track the live classification so a new offset is judged at once.
    always_comb begin
        w_state_next  = r_state;
        w_offset_next = r_offset;
        w_hits_next   = r_hits;
        w_tmo_next    = r_tmo;
        w_loss_next   = r_loss;
        case (r_state)
            c_st_search: begin
                w_hits_next = w_is_ctrl ? sat_inc(r_hits) : '0;
                w_tmo_next  = sat_inc(r_tmo);
                if (r_hits >= c_lock_cnt) begin
                    w_state_next = c_st_locked;
                    w_loss_next  = '0;
                end else if (r_tmo >= c_search_last) begin
                    w_offset_next = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    w_hits_next   = '0;
                    w_tmo_next    = '0;
                end
            end
            c_st_locked: begin
                w_loss_next = w_is_ctrl ? '0 : sat_inc(r_loss);
                if (r_loss >= c_loss_last) begin
                    w_state_next = c_st_search;
                    w_hits_next  = '0;
                    w_tmo_next   = '0;
                end
            end
            default: w_state_next = c_st_search;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_is_ctrl <= 1'b0;
            r_s1_c       <= 2'b00;
            r_s1_data    <= 8'h00;
            r_s2_de      <= 1'b0;
            r_s2_c       <= 2'b00;
            r_s2_data    <= 8'h00;
        end else begin
            r_s1_is_ctrl <= w_is_ctrl;
            r_s1_c       <= w_c;
            r_s1_data    <= w_data;
            r_s2_de      <= ~r_s1_is_ctrl;
            r_s2_c       <= r_s1_is_ctrl ? r_s1_c : 2'b00;
            r_s2_data    <= r_s1_is_ctrl ? 8'h00 : r_s1_data;
        end
    end

    always_comb begin
        locked = (r_state == c_st_locked);
        offset = r_offset;
        de     = locked & r_s2_de;
        c      = locked ? r_s2_c : 2'b00;
        data   = locked ? r_s2_data : 8'h00;
    end

endmodule
`default_nettype wire

// File: tb/tb_dvi_rx_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_dvi_rx_channel
// Description : Self-checking bench for dvi_rx_channel: alignment hunt, lock,
//               symbol decode, loss of lock and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvi_rx_channel;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din   = 10'd0;
    logic       locked;
    logic [3:0] offset;
    logic       de;
    logic [1:0] c;
    logic [7:0] data;

    dvi_rx_channel dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .locked (locked),
        .offset (offset),
        .de     (de),
        .c      (c),
        .data   (data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] sym;
        logic       de;
        logic [1:0] c;
        logic [7:0] data;
    } vec_t;

    typedef struct {
        int unsigned due;
        logic [10:0] exp;
    } sb_t;

    vec_t        vt[9];
    sb_t         sbq[$];
    int unsigned cyc      = 0;
    int unsigned n_pass   = 0;
    int unsigned n_total  = 0;
    int unsigned g_off    = 0;
    logic [9:0]  prev_sym = 10'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (tick %0d)", name, got, exp, cyc);
    endtask

    task automatic tick();
        sb_t it;
        @(posedge clk);
        #1;
        cyc++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            it = sbq.pop_front();
            check("sb_de_c_data", {21'd0, de, c, data}, {21'd0, it.exp});
        end
    endtask

    // Serialise a symbol so it lands aligned at bit offset g_off.
    task automatic drive_sym(input logic [9:0] sym, input bit push, input logic [10:0] exp);
        logic [19:0] pair;
        sb_t it;
        pair = {sym, prev_sym};
        din  = 10'(pair >> (10 - g_off));
        prev_sym = sym;
        if (push) begin
            it.due = cyc + 3;
            it.exp = exp;
            sbq.push_back(it);
        end
        tick();
    endtask

    task automatic run_until_lock(input logic [9:0] sym, input int budget,
                                  output int t_lock, output logic [3:0] off_at_lock);
        t_lock      = -1;
        off_at_lock = 4'hF;
        for (int t = 1; t <= budget; t++) begin
            drive_sym(sym, 1'b0, 11'd0);
            if (locked === 1'b1) begin
                t_lock      = t;
                off_at_lock = offset;
                break;
            end
        end
    endtask

    int         t_lock;
    logic [3:0] off_lock;
    int         n_unlock;
    logic [9:0] tok0;

    initial begin
        vt[0] = '{10'b1101010100, 1'b0, 2'b00, 8'h00};
        vt[1] = '{10'b0010101011, 1'b0, 2'b01, 8'h00};
        vt[2] = '{10'b0101010100, 1'b0, 2'b10, 8'h00};
        vt[3] = '{10'b1010101011, 1'b0, 2'b11, 8'h00};
        vt[4] = '{10'h100,        1'b1, 2'b00, 8'h00};
        vt[5] = '{10'h1FF,        1'b1, 2'b00, 8'h01};
        vt[6] = '{10'h2FF,        1'b1, 2'b00, 8'hFE};
        vt[7] = '{10'h155,        1'b1, 2'b00, 8'hFF};
        vt[8] = '{10'h300,        1'b1, 2'b00, 8'h01};
        tok0  = vt[0].sym;

        // Reset held with random input: everything at reset values.
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = 10'($urandom);
            tick();
            check("reset_outputs", {16'd0, locked, offset, de, c, data}, 32'd0);
        end
        rst_n = 1'b1;
        prev_sym = 10'd0;

        // Aligned token stream locks 66 ticks after release.
        g_off = 0;
        run_until_lock(tok0, 200, t_lock, off_lock);
        check("lock_latency_off0", t_lock, 66);
        check("lock_offset_off0", {28'd0, off_lock}, 0);
        check("lock_first_symbol", {21'd0, de, c, data}, 0);

        // Stream delayed by 3 bits: hunt steps offsets, locks only at 3.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        g_off = 3;
        prev_sym = 10'd0;
        t_lock = -1;
        for (int t = 1; t <= 7000; t++) begin
            drive_sym(tok0, 1'b0, 11'd0);
            if (t == 2047) check("offset_before_step", {28'd0, offset}, 0);
            if (t == 2048) check("offset_step1", {28'd0, offset}, 1);
            if (t == 4096) check("offset_step2", {28'd0, offset}, 2);
            if (t == 6144) check("offset_step3", {28'd0, offset}, 3);
            if (locked === 1'b1) begin
                t_lock = t;
                break;
            end
        end
        check("lock_latency_off3", t_lock, 3 * 2048 + 65);
        check("lock_offset_off3", {28'd0, offset}, 3);

        // Table of tokens and data symbols through the scoreboard.
        for (int i = 0; i < 9; i++) begin
            drive_sym(vt[i].sym, 1'b1, {vt[i].de, vt[i].c, vt[i].data});
        end

        // Two 640x480 lines: 160 tokens then 640 data symbols.
        n_unlock = 0;
        for (int ln = 0; ln < 2; ln++) begin
            for (int k = 0; k < 160; k++) begin
                drive_sym(vt[k % 4].sym, 1'b1, {vt[k % 4].de, vt[k % 4].c, vt[k % 4].data});
                if (locked !== 1'b1) n_unlock++;
            end
            for (int k = 0; k < 640; k++) begin
                drive_sym(vt[4 + k % 5].sym, 1'b1,
                          {vt[4 + k % 5].de, vt[4 + k % 5].c, vt[4 + k % 5].data});
                if (locked !== 1'b1) n_unlock++;
            end
        end
        for (int k = 0; k < 3; k++) drive_sym(tok0, 1'b1, 11'd0);
        check("lock_held_lines", n_unlock, 0);

        // Data only: lock drops after the loss timeout, outputs zeroed.
        for (int k = 0; k < 2052; k++) begin
            drive_sym(vt[4 + k % 5].sym, 1'b1,
                      (k <= 2045) ? {vt[4 + k % 5].de, vt[4 + k % 5].c, vt[4 + k % 5].data}
                                  : 11'd0);
            if (k == 2047) check("lock_before_loss", {31'd0, locked}, 1);
            if (k == 2048) begin
                check("lock_after_loss", {31'd0, locked}, 0);
                check("offset_after_loss", {28'd0, offset}, 3);
            end
        end

        // Tokens restored: relock after 64 hits.
        run_until_lock(vt[1].sym, 200, t_lock, off_lock);
        check("relock_latency", t_lock, 66);
        check("relock_offset", {28'd0, off_lock}, 3);
        check("scoreboard_drained", sbq.size(), 0);

        // Lock at offset 5, then a single-cycle reset pulse.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        rst_n = 1'b1;
        g_off = 5;
        prev_sym = 10'd0;
        run_until_lock(tok0, 11000, t_lock, off_lock);
        check("lock_latency_off5", t_lock, 5 * 2048 + 65);
        check("lock_offset_off5", {28'd0, off_lock}, 5);
        rst_n = 1'b0;
        drive_sym(tok0, 1'b0, 11'd0);
        rst_n = 1'b1;
        check("pulse_reset_outputs", {16'd0, locked, offset, de, c, data}, 32'd0);
        drive_sym(tok0, 1'b0, 11'd0);
        check("pulse_reset_search", {31'd0, locked}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
